regfile_wb_arbiter: RTL

Sequencer and arbiter for the single write port of `registerfile`.
- After reset, optionally sweeps x1..x31 to a known value, since the register file has no reset of its own.
- In normal running, shares the write port between the execute (ALU) and memory (load) writeback sources using round-robin with a valid/ready handshake.
- Drives `RegWrite`/`addr`/`WriteData` from registers.
- Halts writeback permanently once `finish_flag` is seen.

---
 rtl/regfile_ctrl_pkg.sv | 7 +
 rtl/regfile_wb_arbiter_if.sv | 25 ++
 rtl/regfile_wb_arbiter_rr_arb2.sv | 24 ++
 rtl/regfile_wb_arbiter.sv | 85 ++++++++
 4 files changed

// File: rtl/regfile_ctrl_pkg.sv
// regfile_ctrl_pkg: shared widths and enums for the register-file writeback control slice.
package regfile_ctrl_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS = 32;
    typedef enum logic [1:0] {CLEAR, RUN, HALT} wb_state_t;
    typedef enum logic {SRC_EX, SRC_MEM} src_t;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: ex/mem writeback requests and register-file write port.
interface regfile_wb_arbiter_if;
    import regfile_ctrl_pkg::*;
    logic                  ex_valid;
    logic [REG_ADDR_W-1:0] ex_addr;
    logic [31:0]           ex_data;
    logic                  ex_ready;
    logic                  mem_valid;
    logic [REG_ADDR_W-1:0] mem_addr;
    logic [31:0]           mem_data;
    logic                  mem_ready;
    logic                  RegWrite;
    logic [REG_ADDR_W-1:0] addr;
    logic [31:0]           WriteData;
    logic                  init_done;
    logic [15:0]           wr_count;
    modport slave (
        input  ex_valid, ex_addr, ex_data, mem_valid, mem_addr, mem_data,
        output ex_ready, mem_ready, RegWrite, addr, WriteData, init_done, wr_count
    );
    modport master (
        output ex_valid, ex_addr, ex_data, mem_valid, mem_addr, mem_data,
        input  ex_ready, mem_ready, RegWrite, addr, WriteData, init_done, wr_count
    );
endinterface

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// rr_arb2: two-requester round-robin arbiter; on a tie the source not granted last time wins.
module rr_arb2
    import regfile_ctrl_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic req_ex,
    input  logic req_mem,
    input  logic advance,
    output logic gnt_ex,
    output logic gnt_mem
);
    src_t last_q, last_d;
    always_comb begin
        gnt_ex  = enable && req_ex && (!req_mem || last_q == SRC_MEM);
        gnt_mem = enable && req_mem && (!req_ex || last_q == SRC_EX);
        last_d  = advance ? (gnt_mem ? SRC_MEM : SRC_EX) : last_q;
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) last_q <= SRC_EX;
        else        last_q <= last_d;
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: post-reset x1..x31 sweep, then round-robin ex/mem writeback until finish_flag.
module regfile_wb_arbiter
    import regfile_ctrl_pkg::*;
#(
    parameter bit          CLEAR_ON_RESET = 1'b1,
    parameter logic [31:0] CLEAR_VALUE    = 32'd0
) (
    input  logic clock,
    input  logic reset,
    input  logic finish_flag,
    regfile_wb_arbiter_if.slave wb
);
    localparam wb_state_t INIT_STATE = CLEAR_ON_RESET ? CLEAR : RUN;
    wb_state_t             state_q, state_d;
    logic [REG_ADDR_W-1:0] ptr_q, ptr_d, addr_q, addr_d, sel_addr;
    logic [31:0]           data_q, data_d, sel_data;
    logic [15:0]           cnt_q, cnt_d;
    logic                  we_q, we_d, done_q, done_d;
    logic                  gnt_ex, gnt_mem, take;
    rr_arb2 u_arb (
        .clock   (clock),
        .reset   (reset),
        .enable  (state_q == RUN && !finish_flag),
        .req_ex  (wb.ex_valid),
        .req_mem (wb.mem_valid),
        .advance (take),
        .gnt_ex  (gnt_ex),
        .gnt_mem (gnt_mem)
    );
    assign take         = gnt_ex || gnt_mem;
    assign sel_addr     = gnt_mem ? wb.mem_addr : wb.ex_addr;
    assign sel_data     = gnt_mem ? wb.mem_data : wb.ex_data;
    assign wb.ex_ready  = gnt_ex;
    assign wb.mem_ready = gnt_mem;
    assign wb.RegWrite  = we_q;
    assign wb.addr      = addr_q;
    assign wb.WriteData = data_q;
    assign wb.init_done = done_q;
    assign wb.wr_count  = cnt_q;
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        done_d  = state_q != CLEAR;
        if (state_q == CLEAR) begin
            we_d    = 1'b1;
            addr_d  = ptr_q;
            data_d  = CLEAR_VALUE;
            ptr_d   = ptr_q + 1'b1;
            state_d = ptr_q == REG_ADDR_W'(NUM_REGS - 1) ? RUN : CLEAR;
        end else if (state_q == RUN) begin
            if (finish_flag) begin
                state_d = HALT;
            end else if (take) begin
                addr_d = sel_addr;
                data_d = sel_data;
                // x0 requests are accepted but never reach the register file
                we_d   = sel_addr != '0;
                cnt_d  = cnt_q + 16'(we_d && cnt_q != 16'hFFFF);
            end
        end
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= INIT_STATE;
            ptr_q   <= REG_ADDR_W'(1);
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            done_q  <= !CLEAR_ON_RESET;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end
endmodule
